// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage core.
// Turns registered EX results into data-memory req/ack transactions,
// freezes EX/MEM while a transaction is outstanding, and holds the
// MEM/WB register. A bounded wait timer aborts transactions memory never acks.
module mem_stage #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid_in,
    input  logic [15:0] mem_addr_in,
    input  logic [2:0]  rdest_addr_in,
    input  logic [31:0] rdest_data_in,
    input  logic        store_in,
    input  logic        load_in,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [2:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        err_out
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [2:0]  lat_rdest;
    logic        lat_is_load;
    logic        mem_op;
    logic        timeout_hit;

    // Decode the live instruction and the wait-limit condition.
    always_comb begin
        mem_op      = valid_in & (load_in | store_in);
        timeout_hit = (wait_cnt == 8'(TIMEOUT - 1));
    end

    // Freeze EX/MEM while a memory op is starting or still waiting for ack.
    always_comb begin
        stall_out = 1'b0;
        if (state == IDLE) begin
            stall_out = mem_op;
        end else begin
            stall_out = ~dmem_ack & ~timeout_hit;
        end
    end

    // Transaction FSM, memory request registers and MEM/WB register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            lat_rdest   <= '0;
            lat_is_load <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            wb_valid    <= 1'b0;
            wb_we       <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            err_out     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        dmem_addr   <= mem_addr_in;
                        dmem_we     <= store_in;
                        dmem_wdata  <= rdest_data_in;
                        dmem_req    <= 1'b1;
                        lat_rdest   <= rdest_addr_in;
                        // Store takes precedence when both kind bits are set.
                        lat_is_load <= load_in & ~store_in;
                        wait_cnt    <= '0;
                        wb_valid    <= 1'b0;
                        state       <= BUSY;
                    end else begin
                        wb_valid <= valid_in;
                        wb_we    <= valid_in;
                        wb_addr  <= rdest_addr_in;
                        wb_data  <= rdest_data_in;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_addr  <= lat_rdest;
                        wb_we    <= lat_is_load;
                        wb_data  <= lat_is_load ? dmem_rdata : '0;
                        state    <= IDLE;
                    end else if (timeout_hit) begin
                        dmem_req <= 1'b0;
                        err_out  <= 1'b1;
                        wb_valid <= 1'b1;
                        wb_we    <= 1'b0;
                        wb_addr  <= lat_rdest;
                        wb_data  <= '0;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        wb_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage.
// Each instruction is scheduled at transaction level: the bench chooses the
// ack delay, derives the stall pattern and the resulting writeback directly
// from the stage's rules, and a compare process checks every cycle.
module tb_mem_stage;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        resetn;
    logic        valid_in;
    logic [15:0] mem_addr_in;
    logic [2:0]  rdest_addr_in;
    logic [31:0] rdest_data_in;
    logic        store_in;
    logic        load_in;
    logic        stall_out;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        wb_valid;
    logic        wb_we;
    logic [2:0]  wb_addr;
    logic [31:0] wb_data;
    logic        err_out;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .valid_in     (valid_in),
        .mem_addr_in  (mem_addr_in),
        .rdest_addr_in(rdest_addr_in),
        .rdest_data_in(rdest_data_in),
        .store_in     (store_in),
        .load_in      (load_in),
        .stall_out    (stall_out),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack),
        .wb_valid     (wb_valid),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .err_out      (err_out)
    );

    // Expected registered outputs of the stage.
    typedef struct packed {
        logic        req;
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        wbv;
        logic        wbwe;
        logic        wba_ok;
        logic [2:0]  wba;
        logic [31:0] wbd;
        logic        err;
    } exp_t;

    exp_t e;          // expectation for the current cycle
    exp_t p;          // expectation after the coming edge
    logic e_stall;
    logic s_chk;      // stall expectation meaningful this cycle
    logic o_chk;      // registered outputs meaningful this cycle
    int   n_chk;
    int   n_fail;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Per-cycle comparison against the transaction-level expectation.
    always @(negedge clk) begin
        if (o_chk) begin
            chk("dmem_req", 32'(dmem_req), 32'(e.req));
            if (e.req) begin
                chk("dmem_we", 32'(dmem_we), 32'(e.we));
                chk("dmem_addr", 32'(dmem_addr), 32'(e.addr));
                chk("dmem_wdata", dmem_wdata, e.wdata);
            end
            chk("wb_valid", 32'(wb_valid), 32'(e.wbv));
            if (e.wbv) begin
                chk("wb_we", 32'(wb_we), 32'(e.wbwe));
                chk("wb_data", wb_data, e.wbd);
                if (e.wba_ok) chk("wb_addr", 32'(wb_addr), 32'(e.wba));
            end
            chk("err_out", 32'(err_out), 32'(e.err));
            if (s_chk) chk("stall_out", 32'(stall_out), 32'(e_stall));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            e = p;
            resetn = 1'b0;
            valid_in = 1'b0;
            load_in = 1'b0;
            store_in = 1'b0;
            dmem_ack = 1'b0;
            s_chk = 1'b0;
            p = '0;
            tick();
        end
    endtask

    // Non-memory instruction (or bubble); one cycle in IDLE.
    task automatic do_alu(input logic v, input logic [2:0] rd, input logic [31:0] d);
        e = p;
        resetn = 1'b1;
        valid_in = v;
        rdest_addr_in = rd;
        rdest_data_in = d;
        mem_addr_in = 16'($urandom);
        // Memory kind bits on a bubble must not start a transaction.
        load_in = v ? 1'b0 : 1'($urandom);
        store_in = v ? 1'b0 : 1'($urandom);
        dmem_ack = 1'($urandom);
        dmem_rdata = $urandom;
        e_stall = 1'b0;
        s_chk = 1'b1;
        p.req = 1'b0;
        p.wbv = v;
        p.wbwe = v;
        p.wba = rd;
        p.wba_ok = 1'b1;
        p.wbd = d;
        tick();
    endtask

    // Memory op: ack arrives in BUSY cycle number dly (1-based); dly > TO
    // means memory never answers. rst_at >= 0 asserts reset in that BUSY cycle.
    task automatic do_mem(input logic st, input logic ld, input logic [15:0] a,
                          input logic [2:0] rd, input logic [31:0] d,
                          input int dly, input logic [31:0] rdata, input int rst_at);
        int  n;
        logic acked;
        logic is_load;
        acked = (dly <= int'(TO));
        n = acked ? dly : int'(TO);
        is_load = ld & ~st;
        // IDLE cycle presenting the instruction; an ack here is ignored.
        e = p;
        resetn = 1'b1;
        valid_in = 1'b1;
        store_in = st;
        load_in = ld;
        mem_addr_in = a;
        rdest_addr_in = rd;
        rdest_data_in = d;
        dmem_ack = 1'($urandom);
        dmem_rdata = $urandom;
        e_stall = 1'b1;
        s_chk = 1'b1;
        p.wbv = 1'b0;
        p.req = 1'b1;
        p.we = st;
        p.addr = a;
        p.wdata = d;
        tick();
        for (int k = 0; k < n; k++) begin
            e = p;
            s_chk = 1'b1;
            if (k == rst_at) begin
                resetn = 1'b0;
                s_chk = 1'b0;
                dmem_ack = 1'b0;
                p = '0;
                tick();
                return;
            end
            dmem_ack = acked && (k == n - 1);
            dmem_rdata = dmem_ack ? rdata : $urandom;
            e_stall = (k == n - 1) ? 1'b0 : 1'b1;
            if (k == n - 1) begin
                p.req = 1'b0;
                p.wbv = 1'b1;
                p.wba = rd;
                p.wba_ok = acked;
                if (acked) begin
                    p.wbwe = is_load;
                    p.wbd = is_load ? rdata : 32'h0;
                end else begin
                    p.wbwe = 1'b0;
                    p.wbd = 32'h0;
                    p.err = 1'b1;
                end
            end else begin
                p.wbv = 1'b0;
            end
            tick();
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        o_chk = 1'b0;
        s_chk = 1'b0;
        e_stall = 1'b0;
        p = '0;
        e = '0;
        resetn = 1'b0;
        valid_in = 1'b0;
        load_in = 1'b0;
        store_in = 1'b0;
        mem_addr_in = '0;
        rdest_addr_in = '0;
        rdest_data_in = '0;
        dmem_ack = 1'b0;
        dmem_rdata = '0;

        do_reset(2);
        o_chk = 1'b1;
        // Reset state with a bubble on the inputs.
        chk("rst_dmem_req", 32'(dmem_req), 32'h0);
        chk("rst_wb_valid", 32'(wb_valid), 32'h0);
        chk("rst_err", 32'(err_out), 32'h0);
        chk("rst_stall", 32'(stall_out), 32'h0);

        // ALU op: one-cycle writeback.
        do_alu(1'b1, 3'd5, 32'h1234_5678);
        chk("alu_wb_valid", 32'(wb_valid), 32'h1);
        chk("alu_wb_addr", 32'(wb_addr), 32'h5);
        chk("alu_wb_data", wb_data, 32'h1234_5678);

        // Store acked in first BUSY cycle.
        do_mem(1'b1, 1'b0, 16'h00A0, 3'd1, 32'hDEAD_BEEF, 1, 32'h0, -1);
        chk("st_wb_valid", 32'(wb_valid), 32'h1);
        chk("st_wb_we", 32'(wb_we), 32'h0);

        // Load acked on the 4th (= last allowed) BUSY cycle: ack beats timeout.
        do_mem(1'b0, 1'b1, 16'h0010, 3'd3, 32'h0, 4, 32'hCAFE_F00D, -1);
        chk("ld_wb_we", 32'(wb_we), 32'h1);
        chk("ld_wb_addr", 32'(wb_addr), 32'h3);
        chk("ld_wb_data", wb_data, 32'hCAFE_F00D);
        chk("ld_err", 32'(err_out), 32'h0);

        // Load never acked: abort after TO BUSY cycles, sticky error.
        do_mem(1'b0, 1'b1, 16'h0020, 3'd6, 32'h0, int'(TO) + 1, 32'h0, -1);
        chk("to_err", 32'(err_out), 32'h1);
        chk("to_wb_valid", 32'(wb_valid), 32'h1);
        chk("to_wb_we", 32'(wb_we), 32'h0);

        // Back-to-back load, load, ALU.
        do_mem(1'b0, 1'b1, 16'h0030, 3'd2, 32'h0, 1, 32'h1111_2222, -1);
        do_mem(1'b0, 1'b1, 16'h0031, 3'd4, 32'h0, 1, 32'h3333_4444, -1);
        do_alu(1'b1, 3'd7, 32'h5555_6666);
        chk("b2b_wb_data", wb_data, 32'h5555_6666);
        chk("err_sticky", 32'(err_out), 32'h1);

        // Reset during 2nd BUSY cycle abandons the transaction.
        do_mem(1'b1, 1'b1, 16'h0040, 3'd1, 32'h7777_8888, 3, 32'h0, 1);
        chk("mrst_req", 32'(dmem_req), 32'h0);
        chk("mrst_wb_valid", 32'(wb_valid), 32'h0);
        chk("mrst_err", 32'(err_out), 32'h0);
        do_alu(1'b0, 3'd0, 32'h0);

        // Randomized mix.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 4) begin
                do_alu(1'($urandom_range(0, 9) < 8), 3'($urandom), $urandom);
            end else begin
                int kind;
                int rst_at;
                kind = $urandom_range(0, 2);
                rst_at = ($urandom_range(0, 19) == 0) ? $urandom_range(0, TO - 1) : -1;
                do_mem(kind != 0, kind != 1, 16'($urandom), 3'($urandom), $urandom,
                       $urandom_range(1, TO + 1), $urandom, rst_at);
            end
        end
        do_alu(1'b0, 3'd0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage core: sits directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB boundary. It turns the registered EX results into data-memory transactions over a req/ack handshake, freezes the EX/MEM register while a transaction is outstanding, and registers the writeback fields (MEM/WB register is internal). A bounded wait timer guarantees forward progress if memory never acknowledges.

## Interface
- TIMEOUT, 64, max BUSY cycles per transaction before abort; legal 1..255
- clk  in  1  system clock, all state updates on rising edge
- resetn  in  1  synchronous, active-low reset
- valid_in  in  1  EX/MEM register holds a live instruction (0 = bubble)
- mem_addr_in  in  16  data-memory word address from EX/MEM
- rdest_addr_in  in  3  destination register index
- rdest_data_in  in  32  ALU result, or store data when store_in=1
- store_in  in  1  instruction is a store
- load_in  in  1  instruction is a load
- stall_out  out  1  hold EX/MEM contents; integration ties EXtoMEM_Wen = ~stall_out
- dmem_req  out  1  transaction request, registered
- dmem_we  out  1  1 = write, registered
- dmem_addr  out  16  transaction address, registered
- dmem_wdata  out  32  write data, registered
- dmem_rdata  in  32  read data, valid when dmem_ack=1
- dmem_ack  in  1  transaction complete
- wb_valid  out  1  writeback fields valid this cycle
- wb_we  out  1  write register file
- wb_addr  out  3  register index
- wb_data  out  32  register write data
- err_out  out  1  sticky timeout flag, cleared only by reset

## Operation
- mem_op = valid_in & (load_in | store_in); store_in=1 with load_in=1 is treated as a store.
- FSM states IDLE, BUSY. Reset -> IDLE.
- IDLE, mem_op=0: stall_out=0; next edge wb_valid<=valid_in, wb_we<=valid_in, wb_addr<=rdest_addr_in, wb_data<=rdest_data_in.
- IDLE, mem_op=1: stall_out=1; next edge capture dmem_addr<=mem_addr_in, dmem_we<=store_in, dmem_wdata<=rdest_data_in, latch rdest_addr, load/store kind, dmem_req<=1, wait counter<=0, state->BUSY; wb_valid<=0.
- BUSY: dmem_req=1, outputs stable. stall_out = ~dmem_ack & ~timeout_hit, timeout_hit = (counter == TIMEOUT-1).
- BUSY & dmem_ack: next edge dmem_req<=0, state->IDLE, wb_valid<=1, wb_addr<=latched index; load: wb_we<=1, wb_data<=dmem_rdata; store: wb_we<=0, wb_data<=0.
- BUSY & ~dmem_ack & timeout_hit: next edge dmem_req<=0, state->IDLE, err_out<=1, wb_valid<=1, wb_we<=0, wb_data<=0.
- BUSY & neither: counter<=counter+1 (8-bit, never wraps since TIMEOUT<=255), wb_valid<=0.
- dmem_ack and timeout_hit same cycle: ack wins, err_out unchanged.
- dmem_ack while IDLE: ignored.

## Timing
- Reset (resetn=0 at edge): state IDLE, counter 0, dmem_req/dmem_we/dmem_addr/dmem_wdata 0, wb_valid/wb_we/wb_addr/wb_data 0, err_out 0; stall_out 0 while in IDLE with mem_op=0.
- Reset mid-BUSY: transaction abandoned, dmem_req low after that edge, no writeback issued.
- Non-memory instruction: 1-cycle latency to wb_*.
- Memory op with ack in first BUSY cycle: stall_out high 1 cycle, wb_* valid 2 cycles after instruction appears; each extra ack-wait cycle adds 1.
- Timeout: exactly TIMEOUT BUSY cycles, stall_out high TIMEOUT cycles total (IDLE cycle + TIMEOUT-1 BUSY cycles).
- stall_out is combinational from state, counter, dmem_ack, mem_op; EX/MEM advances on the edge where stall_out=0, so each op executes once.

## Test plan
- Reset then valid ALU op rdest_addr=5, data=0x1234_5678 -> next cycle wb_valid=1, wb_we=1, wb_addr=5, wb_data=0x12345678, dmem_req=0.
- Store addr 0x00A0, data 0xDEADBEEF, ack in first BUSY cycle -> dmem_req=1, dmem_we=1, dmem_addr=0x00A0, dmem_wdata=0xDEADBEEF for 1 cycle; stall_out high 1 cycle; wb_valid=1, wb_we=0.
- Load addr 0x0010, rdest 3, ack after 4 BUSY cycles with rdata 0xCAFEF00D -> stall_out high 4 cycles, wb_we=1, wb_addr=3, wb_data=0xCAFEF00D.
- TIMEOUT=4, load with no ack -> dmem_req high 4 cycles then low, err_out=1 and stays 1, wb_valid=1, wb_we=0; second TIMEOUT=4 run with ack on 4th BUSY cycle -> normal completion.
- Back-to-back load, load, ALU op with ack each first cycle -> three wb_valid pulses in order, no duplicate transaction; resetn=0 during 2nd BUSY -> dmem_req 0, all outputs 0 next cycle.
